mem_port_arbiter: RTL

//  Shares one single-ported unified memory between instruction fetch (IF) and data access (DA) requesters.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access: data wins,
// fetch is forced in after STARVE_MAX data grants, and a watchdog aborts stalled accesses.
// Optional ARB_PERF_CNT_EN adds fetch-wait and data-grant performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       perf_if_wait,
    output logic [15:0]       perf_d_grants
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IF_BUSY,
        S_D_BUSY
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                w_grantIf;
    logic                w_grantD;
    logic                w_done;
    logic                w_abort;
    logic                w_starved;
    logic                w_wdExpired;
    logic [3:0]          r_starveCnt;
    logic [7:0]          r_wdCnt;
    logic                r_ifAck;
    logic                r_dAck;
    logic                r_err;
    logic [DATA_W-1:0]   r_ifRdata;
    logic [DATA_W-1:0]   r_dRdata;
    logic                r_memEn;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [DATA_W-1:0]   r_memWdata;

    assign w_starved   = if_req && (r_starveCnt == 4'(STARVE_MAX));
    assign w_wdExpired = (r_wdCnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_nextState;
    end

    // A completion in the same cycle as the last watchdog tick is honoured, not aborted.
    always_comb begin
        w_nextState = r_state;
        w_grantIf   = 1'b0;
        w_grantD    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (d_req && !w_starved) begin
                    w_grantD    = 1'b1;
                    w_nextState = S_D_BUSY;
                end else if (if_req) begin
                    w_grantIf   = 1'b1;
                    w_nextState = S_IF_BUSY;
                end
            end
            S_IF_BUSY, S_D_BUSY: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_nextState = S_IDLE;
                end else if (w_wdExpired) begin
                    w_abort     = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifAck    <= 1'b0;
            r_dAck     <= 1'b0;
            r_err      <= 1'b0;
            r_ifRdata  <= '0;
            r_dRdata   <= '0;
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_wdCnt    <= '0;
        end else begin
            r_ifAck <= 1'b0;
            r_dAck  <= 1'b0;
            r_err   <= 1'b0;
            if (w_grantIf || w_grantD) begin
                r_memEn    <= 1'b1;
                r_memWe    <= w_grantD && d_we;
                r_memAddr  <= w_grantD ? d_addr : if_addr;
                r_memWdata <= w_grantD ? d_wdata : '0;
                r_wdCnt    <= '0;
            end else if (w_done || w_abort) begin
                r_memEn <= 1'b0;
                r_memWe <= 1'b0;
                r_err   <= w_abort;
                r_wdCnt <= '0;
                if (r_state == S_IF_BUSY) begin
                    r_ifAck   <= 1'b1;
                    r_ifRdata <= w_abort ? '0 : mem_rdata;
                end else begin
                    r_dAck   <= 1'b1;
                    r_dRdata <= (w_abort || r_memWe) ? '0 : mem_rdata;
                end
            end else if (r_state != S_IDLE) begin
                r_wdCnt <= r_wdCnt + 8'd1;
            end
        end
    end

    // Fetch starvation only accumulates while fetch is actually waiting at a data grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starveCnt <= '0;
        end else if (w_grantIf) begin
            r_starveCnt <= '0;
        end else if (w_grantD) begin
            if (!if_req)                                 r_starveCnt <= '0;
            else if (r_starveCnt != 4'(STARVE_MAX))      r_starveCnt <= r_starveCnt + 4'd1;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] r_perfIfWait;
    logic [15:0] r_perfDGrants;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perfIfWait  <= '0;
            r_perfDGrants <= '0;
        end else begin
            if (if_req && !r_ifAck && (r_perfIfWait != 16'hFFFF))
                r_perfIfWait <= r_perfIfWait + 16'd1;
            if (w_grantD && (r_perfDGrants != 16'hFFFF))
                r_perfDGrants <= r_perfDGrants + 16'd1;
        end
    end

    assign perf_if_wait  = r_perfIfWait;
    assign perf_d_grants = r_perfDGrants;
`endif

    assign if_rdata  = r_ifRdata;
    assign if_ack    = r_ifAck;
    assign d_rdata   = r_dRdata;
    assign d_ack     = r_dAck;
    assign err       = r_err;
    assign mem_en    = r_memEn;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;

endmodule
